// File: rtl/mem_wb_pkg.sv
// Shared defines for the MEM/WB pipeline register: bus widths, cleared values,
// stall bit indices and the per-edge action selection.
package mem_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] RegAddrBus;
    typedef logic [REG_DATA_W-1:0] RegDataBus;

    localparam RegAddrBus NOPRegAddr   = '0;
    localparam RegDataBus ZeroWord     = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_CAPTURE
    } wb_act_e;

    // Exactly one action per edge, highest priority first.
    function automatic wb_act_e wb_action(input logic rst_n, input logic flush,
                                          input logic stall_mem, input logic stall_wb);
        if (!rst_n)         return ACT_RESET;
        else if (flush)     return ACT_FLUSH;
        else if (stall_wb)  return ACT_HOLD;
        else if (stall_mem) return ACT_BUBBLE;
        else                return ACT_CAPTURE;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register feeding the regfile, hilo_reg and LLbit_reg write ports.
// Every output is a flop; stalls either freeze the stage or insert a bubble.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_LLbit_we,
    input  logic              mem_LLbit_value,
    output logic              wb_wreg,
    output logic [ADDR_W-1:0] wb_wd,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_LLbit_we,
    output logic              wb_LLbit_value
);

    logic              r_wreg;
    logic [ADDR_W-1:0] r_wd;
    logic [DATA_W-1:0] r_wdata;
    logic              r_whilo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_LLbit_we;
    logic              r_LLbit_value;

    wb_act_e w_act;
    // Only the MEM and WB stall bits matter to this stage.
    logic    w_unused_stall;

    assign w_act          = wb_action(rst, flush, stall[STALL_MEM], stall[STALL_WB]);
    assign w_unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_CAPTURE: begin
                r_wreg        <= mem_wreg;
                r_wd          <= mem_wd;
                r_wdata       <= mem_wdata;
                r_whilo       <= mem_whilo;
                r_hi          <= mem_hi;
                r_lo          <= mem_lo;
                r_LLbit_we    <= mem_LLbit_we;
                r_LLbit_value <= mem_LLbit_value;
            end
            ACT_HOLD: begin
                r_wreg        <= r_wreg;
                r_wd          <= r_wd;
                r_wdata       <= r_wdata;
                r_whilo       <= r_whilo;
                r_hi          <= r_hi;
                r_lo          <= r_lo;
                r_LLbit_we    <= r_LLbit_we;
                r_LLbit_value <= r_LLbit_value;
            end
            default: begin
                // Reset, flush and bubble all leave a no-op in write-back.
                r_wreg        <= WriteDisable;
                r_wd          <= ADDR_W'(NOPRegAddr);
                r_wdata       <= DATA_W'(ZeroWord);
                r_whilo       <= WriteDisable;
                r_hi          <= DATA_W'(ZeroWord);
                r_lo          <= DATA_W'(ZeroWord);
                r_LLbit_we    <= WriteDisable;
                r_LLbit_value <= 1'b0;
            end
        endcase
    end

    assign wb_wreg        = r_wreg;
    assign wb_wd          = r_wd;
    assign wb_wdata       = r_wdata;
    assign wb_whilo       = r_whilo;
    assign wb_hi          = r_hi;
    assign wb_lo          = r_lo;
    assign wb_LLbit_we    = r_LLbit_we;
    assign wb_LLbit_value = r_LLbit_value;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: reset, capture, bubble, hold, flush, HI/LO/LLbit
// and reset during hold, each with hand-computed expected outputs.
module tb_mem_wb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 1 + AW + DW + 1 + DW + DW + 1 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          mem_wreg;
    logic [AW-1:0] mem_wd;
    logic [DW-1:0] mem_wdata;
    logic          mem_whilo;
    logic [DW-1:0] mem_hi;
    logic [DW-1:0] mem_lo;
    logic          mem_LLbit_we;
    logic          mem_LLbit_value;
    logic          wb_wreg;
    logic [AW-1:0] wb_wd;
    logic [DW-1:0] wb_wdata;
    logic          wb_whilo;
    logic [DW-1:0] wb_hi;
    logic [DW-1:0] wb_lo;
    logic          wb_LLbit_we;
    logic          wb_LLbit_value;

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;

    assign obs = {wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_LLbit_we, wb_LLbit_value};

    mem_wb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
        .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] mk(input logic wreg, input logic [AW-1:0] wd,
                                         input logic [DW-1:0] wdata, input logic whilo,
                                         input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                                         input logic llwe, input logic llv);
        return {wreg, wd, wdata, whilo, hi, lo, llwe, llv};
    endfunction

    task automatic set_mem(input logic wreg, input logic [AW-1:0] wd, input logic [DW-1:0] wdata,
                           input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                           input logic llwe, input logic llv);
        mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata; mem_whilo = whilo;
        mem_hi = hi; mem_lo = lo; mem_LLbit_we = llwe; mem_LLbit_value = llv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; stall = 6'b0;
        set_mem(1, 5'd17, 32'hFFFF_0001, 1, 32'h1111_1111, 32'h2222_2222, 1, 1);
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset obs=%h exp=%h", obs, exp_v); end
        stall = 6'b011111; flush = 1'b1;
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_priority obs=%h exp=%h", obs, exp_v); end
        flush = 1'b0; stall = 6'b0;
    endtask

    task automatic test_capture();
        rst = 1'b1; stall = 6'b0; flush = 1'b0;
        set_mem(1, 5'd8, 32'h1234_5678, 0, 32'h0, 32'h0, 0, 0);
        tick();
        exp_v = mk(1, 5'd8, 32'h1234_5678, 0, 32'h0, 32'h0, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL capture obs=%h exp=%h", obs, exp_v); end
        // data copied even with enables low
        set_mem(0, 5'd31, 32'hCAFE_F00D, 0, 32'h0BAD_0001, 32'h0BAD_0002, 0, 1);
        tick();
        exp_v = mk(0, 5'd31, 32'hCAFE_F00D, 0, 32'h0BAD_0001, 32'h0BAD_0002, 0, 1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL capture_wreg0 obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_bubble();
        set_mem(1, 5'd12, 32'h0F0F_0F0F, 1, 32'h3333_0000, 32'h0000_4444, 1, 1);
        stall = 6'b001111;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL bubble obs=%h exp=%h", obs, exp_v); end
        stall = 6'b0;
        set_mem(1, 5'd13, 32'h7777_8888, 0, 32'h0, 32'h0, 0, 0);
        tick();
        exp_v = mk(1, 5'd13, 32'h7777_8888, 0, 32'h0, 32'h0, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL bubble_release obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_hold();
        stall = 6'b0;
        set_mem(1, 5'd3, 32'hA5A5_A5A5, 0, 32'h0, 32'h0, 0, 0);
        tick();
        exp_v = mk(1, 5'd3, 32'hA5A5_A5A5, 0, 32'h0, 32'h0, 0, 0);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_mem(i[0], AW'(20 + i), 32'h5000_0000 + DW'(i), 1, 32'hEEEE_0000, 32'h0000_EEEE, 1, 1);
            tick();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL hold_%0d obs=%h exp=%h", i, obs, exp_v); end
        end
        // stall[4] without stall[3] still holds
        stall = 6'b010000;
        tick();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hold_wb_only obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_flush();
        stall = 6'b011111; flush = 1'b1;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL flush obs=%h exp=%h", obs, exp_v); end
        flush = 1'b0; stall = 6'b0;
        set_mem(1, 5'd9, 32'h0000_0009, 0, 32'h0, 32'h0, 0, 0);
        tick();
        exp_v = mk(1, 5'd9, 32'h0000_0009, 0, 32'h0, 32'h0, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL flush_release obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_hilo_llbit();
        stall = 6'b0;
        set_mem(0, 5'd0, 32'h0, 1, 32'hDEAD_0000, 32'h0000_BEEF, 1, 1);
        tick();
        exp_v = mk(0, 5'd0, 32'h0, 1, 32'hDEAD_0000, 32'h0000_BEEF, 1, 1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL hilo_llbit obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_hold();
        stall = 6'b0;
        set_mem(1, 5'd21, 32'h2121_2121, 1, 32'h1, 32'h2, 0, 0);
        tick();
        stall = 6'b011111;
        set_mem(1, 5'd22, 32'h2222_2222, 0, 32'h0, 32'h0, 1, 0);
        tick();
        exp_v = mk(1, 5'd21, 32'h2121_2121, 1, 32'h1, 32'h2, 0, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_hold_pre obs=%h exp=%h", obs, exp_v); end
        rst = 1'b0;
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_hold obs=%h exp=%h", obs, exp_v); end
        rst = 1'b1; stall = 6'b0;
        tick();
        exp_v = mk(1, 5'd22, 32'h2222_2222, 0, 32'h0, 32'h0, 1, 0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_hold_resume obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_ignored_bits();
        stall = 6'b100111;
        set_mem(1, 5'd30, 32'h3030_3030, 1, 32'hA0A0_0000, 32'h0000_B0B0, 0, 1);
        tick();
        exp_v = mk(1, 5'd30, 32'h3030_3030, 1, 32'hA0A0_0000, 32'h0000_B0B0, 0, 1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ignored_bits obs=%h exp=%h", obs, exp_v); end
        stall = 6'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1357_9BDF};
        stall = 6'b0;
        for (int i = 0; i < 4; i++) begin
            set_mem(1, AW'(i + 1), vals[i], i[0], ~vals[i], vals[i], i[1], i[0]);
            tick();
            exp_v = mk(1, AW'(i + 1), vals[i], i[0], ~vals[i], vals[i], i[1], i[0]);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b_%0d obs=%h exp=%h", i, obs, exp_v); end
        end
    endtask

    initial begin
        rst = 1'b0; stall = 6'b0; flush = 1'b0;
        set_mem(0, '0, '0, 0, '0, '0, 0, 0);
        test_reset();
        test_capture();
        test_bubble();
        test_hold();
        test_flush();
        test_hilo_llbit();
        test_reset_mid_hold();
        test_ignored_bits();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-back data, HI and LO buses.
REQ-002 Parameter ADDR_W, default 5, width of the destination register address.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
REQ-005 stall  in  6  pipeline stall vector from ctrl; bit 3 = MEM stalled, bit 4 = WB stalled.
REQ-006 flush  in  1  exception flush; clears the stage.
REQ-007 mem_wreg  in  1  register-file write enable from MEM.
REQ-008 mem_wd  in  ADDR_W  destination register address from MEM.
REQ-009 mem_wdata  in  DATA_W  write data from MEM.
REQ-010 mem_whilo  in  1  HI/LO write enable from MEM.
REQ-011 mem_hi, mem_lo  in  DATA_W each  HI and LO values from MEM.
REQ-012 mem_LLbit_we  in  1  LLbit write enable from MEM.
REQ-013 mem_LLbit_value  in  1  LLbit value from MEM.
REQ-014 wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_LLbit_we, wb_LLbit_value  out  same widths as the matching mem_* inputs  registered write-back controls to regfile, hilo_reg and LLbit_reg.

Function
REQ-015 All outputs are registers; no combinational path from any input to any output.
REQ-016 Latency: a MEM-stage value presented with no stall or flush appears on wb_* after exactly one rising edge.
REQ-017 Each rising edge takes exactly one action, highest priority first: reset, flush, hold, bubble, capture.
REQ-018 Reset: rst==0 clears every output.
REQ-019 Flush: flush==1 with rst==1 clears every output, even when stall bits are set.
REQ-020 Hold: stall[4]==1 (no flush) keeps every output unchanged.
REQ-021 Bubble: stall[3]==1 and stall[4]==0 clears every output, so a stalled MEM stage does not write back twice.
REQ-022 Capture: stall[3]==0 and stall[4]==0 loads every wb_* output from its matching mem_* input.
REQ-023 stall[3]==0 with stall[4]==1 is never produced by ctrl; if it occurs, the hold rule applies.
REQ-024 Cleared values: wb_wd = NOPRegAddr (0), wb_wdata/wb_hi/wb_lo = ZeroWord, all enables = WriteDisable, wb_LLbit_value = 0.
REQ-025 Data fields load as well as enables: wb_wdata loads even when mem_wreg==0, so a capture is a bit-exact copy of the inputs.
REQ-026 stall bits 0-2 and 5 have no effect.
REQ-027 A reset asserted while a hold is in progress clears the outputs at that edge; capture resumes on the first edge after rst returns high.

Reset
REQ-028 Reset is synchronous and active-low, sampled only on rising clk edges; outputs are undefined before the first edge.
REQ-029 Reset gives the cleared values of REQ-024 and takes priority over flush and stall.

Structure
REQ-030 The shared defines file holds RegAddrBus, RegDataBus, NOPRegAddr, ZeroWord, WriteEnable, WriteDisable and the stall bit indices (MEM=3, WB=4).
REQ-031 The block uses one flat always block; no sub-module.
REQ-032 The block sits between mem and the regfile/hilo_reg/LLbit_reg write ports.

Verification
REQ-033 Capture: rst=1, stall=0, mem_wreg=1, mem_wd=5'd8, mem_wdata=32'h1234_5678 -> after 1 edge wb_wreg=1, wb_wd=8, wb_wdata=32'h1234_5678.
REQ-034 Bubble: stall=6'b001111 with valid MEM inputs -> next edge all wb_* = 0; stall=0 -> next edge captures the current inputs.
REQ-035 Hold: capture wd=3/wdata=32'hA5A5_A5A5, then stall=6'b011111 for 3 cycles while inputs change -> outputs stay 3/32'hA5A5_A5A5.
REQ-036 Flush priority: flush=1 with stall=6'b011111 and outputs holding data -> next edge all outputs cleared.
REQ-037 HI/LO/LLbit: mem_whilo=1, mem_hi=32'hDEAD_0000, mem_lo=32'h0000_BEEF, mem_LLbit_we=1, value=1 -> after 1 edge wb_whilo=1, wb_hi/wb_lo match, wb_LLbit_we=1, wb_LLbit_value=1.
REQ-038 Reset mid-hold: hold active, rst=0 for 1 edge -> all outputs 0; rst=1, stall=0 -> next edge captures.
